// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with a 2-entry skid (main + skid).
// Valid/ready on both sides, flush kills held entries, and the control
// strobes are gated by valid so bubbles never write memory or registers.
module ex_mem_pipe #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_branch,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic                  in_mem_to_reg,
  input  logic                  in_reg_write,
  input  logic                  in_zero,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [DATA_W-1:0]     in_write_data,
  input  logic [REG_ADDR_W-1:0] in_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_branch,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic                  out_reg_write,
  output logic                  out_mem_to_reg,
  output logic                  out_zero,
  output logic [DATA_W-1:0]     out_alu_result,
  output logic [DATA_W-1:0]     out_write_data,
  output logic [REG_ADDR_W-1:0] out_rd
);

  typedef struct packed {
    logic                  branch;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic                  zero;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     write_data;
    logic [REG_ADDR_W-1:0] rd;
  } bundle_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t  state_q, state_d;
  bundle_t main_q, main_d;
  bundle_t skid_q, skid_d;
  bundle_t in_b;

  logic in_ready_q, in_ready_d;
  logic out_valid_q, out_valid_d;
  logic out_branch_q, out_branch_d;
  logic out_mem_read_q, out_mem_read_d;
  logic out_mem_write_q, out_mem_write_d;
  logic out_reg_write_q, out_reg_write_d;

  logic in_fire;
  logic out_fire;

  // Pack the EX-side fields into one bundle.
  always_comb begin
    in_b            = '0;
    in_b.branch     = in_branch;
    in_b.mem_read   = in_mem_read;
    in_b.mem_write  = in_mem_write;
    in_b.mem_to_reg = in_mem_to_reg;
    in_b.reg_write  = in_reg_write;
    in_b.zero       = in_zero;
    in_b.alu_result = in_alu_result;
    in_b.write_data = in_write_data;
    in_b.rd         = in_rd;
  end

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // Occupancy FSM: main is always the older entry, skid the younger.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_ONE;
          main_d  = in_b;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_b;
        end else if (in_fire) begin
          state_d = ST_TWO;
          skid_d  = in_b;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_fire) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Flush drops everything, including a bundle arriving this cycle.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  // Registered handshake and valid-gated strobes, derived from next state.
  always_comb begin
    out_valid_d     = (state_d != ST_EMPTY);
    in_ready_d      = (state_d != ST_TWO);
    out_branch_d    = main_d.branch    & out_valid_d;
    out_mem_read_d  = main_d.mem_read  & out_valid_d;
    out_mem_write_d = main_d.mem_write & out_valid_d;
    out_reg_write_d = main_d.reg_write & out_valid_d;
  end

  // State and data registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= ST_EMPTY;
      main_q          <= '0;
      skid_q          <= '0;
      in_ready_q      <= 1'b1;
      out_valid_q     <= 1'b0;
      out_branch_q    <= 1'b0;
      out_mem_read_q  <= 1'b0;
      out_mem_write_q <= 1'b0;
      out_reg_write_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      main_q          <= main_d;
      skid_q          <= skid_d;
      in_ready_q      <= in_ready_d;
      out_valid_q     <= out_valid_d;
      out_branch_q    <= out_branch_d;
      out_mem_read_q  <= out_mem_read_d;
      out_mem_write_q <= out_mem_write_d;
      out_reg_write_q <= out_reg_write_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_branch     = out_branch_q;
  assign out_mem_read   = out_mem_read_q;
  assign out_mem_write  = out_mem_write_q;
  assign out_reg_write  = out_reg_write_q;
  assign out_mem_to_reg = main_q.mem_to_reg;
  assign out_zero       = main_q.zero;
  assign out_alu_result = main_q.alu_result;
  assign out_write_data = main_q.write_data;
  assign out_rd         = main_q.rd;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe: reset, streaming, skid stall, flush,
// bubble gating and reset during a stall.
module tb_ex_mem_pipe;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned REG_ADDR_W = 5;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_branch;
  logic                  in_mem_read;
  logic                  in_mem_write;
  logic                  in_mem_to_reg;
  logic                  in_reg_write;
  logic                  in_zero;
  logic [DATA_W-1:0]     in_alu_result;
  logic [DATA_W-1:0]     in_write_data;
  logic [REG_ADDR_W-1:0] in_rd;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_branch;
  logic                  out_mem_read;
  logic                  out_mem_write;
  logic                  out_reg_write;
  logic                  out_mem_to_reg;
  logic                  out_zero;
  logic [DATA_W-1:0]     out_alu_result;
  logic [DATA_W-1:0]     out_write_data;
  logic [REG_ADDR_W-1:0] out_rd;

  int n_assert = 0;
  int n_fail   = 0;

  ex_mem_pipe #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_branch      (in_branch),
    .in_mem_read    (in_mem_read),
    .in_mem_write   (in_mem_write),
    .in_mem_to_reg  (in_mem_to_reg),
    .in_reg_write   (in_reg_write),
    .in_zero        (in_zero),
    .in_alu_result  (in_alu_result),
    .in_write_data  (in_write_data),
    .in_rd          (in_rd),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_branch     (out_branch),
    .out_mem_read   (out_mem_read),
    .out_mem_write  (out_mem_write),
    .out_reg_write  (out_reg_write),
    .out_mem_to_reg (out_mem_to_reg),
    .out_zero       (out_zero),
    .out_alu_result (out_alu_result),
    .out_write_data (out_write_data),
    .out_rd         (out_rd)
  );

  always #5 clock = ~clock;

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive an EX bundle; write_data = ~alu, rd = alu[4:0], reg_write = 1.
  task automatic set_in(input logic v, input logic [7:0] alu, input logic mw);
    in_valid      = v;
    in_alu_result = alu;
    in_write_data = ~alu;
    in_rd         = alu[4:0];
    in_mem_write  = mw;
    in_reg_write  = 1'b1;
    in_branch     = alu[1];
    in_mem_read   = alu[2];
    in_mem_to_reg = alu[3];
    in_zero       = alu[4];
  endtask

  initial begin
    // 1: reset held two cycles while EX presents a valid bundle
    reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
    set_in(1'b1, 8'hFF, 1'b1);
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_alu",       32'(out_alu_result), 32'h0);
    chk("rst_wdata",     32'(out_write_data), 32'h0);
    chk("rst_rd",        32'(out_rd),    32'h0);
    chk("rst_mem_write", 32'(out_mem_write), 32'd0);
    chk("rst_reg_write", 32'(out_reg_write), 32'd0);
    chk("rst_zero",      32'(out_zero),  32'd0);

    reset = 1'b1;
    set_in(1'b0, 8'h00, 1'b0);
    tick();

    // 2: streaming with out_ready=1, one-cycle latency
    set_in(1'b1, 8'h10, 1'b0); tick();
    chk("s0_valid", 32'(out_valid), 32'd1);
    chk("s0_alu",   32'(out_alu_result), 32'h10);
    chk("s0_ready", 32'(in_ready), 32'd1);
    set_in(1'b1, 8'h11, 1'b1); tick();
    chk("s1_valid", 32'(out_valid), 32'd1);
    chk("s1_alu",   32'(out_alu_result), 32'h11);
    chk("s1_mw",    32'(out_mem_write), 32'd1);
    set_in(1'b1, 8'h12, 1'b0); tick();
    chk("s2_valid", 32'(out_valid), 32'd1);
    chk("s2_alu",   32'(out_alu_result), 32'h12);
    chk("s2_wdata", 32'(out_write_data), 32'hED);
    chk("s2_rd",    32'(out_rd), 32'h12);
    chk("s2_mw",    32'(out_mem_write), 32'd0);
    chk("s2_br",    32'(out_branch), 32'd1);
    set_in(1'b0, 8'h00, 1'b0); tick();
    chk("s_drain_valid", 32'(out_valid), 32'd0);

    // 3: stall fills main then skid, then drain in order
    out_ready = 1'b0;
    set_in(1'b1, 8'hA0, 1'b0); tick();
    chk("k0_alu",   32'(out_alu_result), 32'hA0);
    chk("k0_ready", 32'(in_ready), 32'd1);
    set_in(1'b1, 8'hA1, 1'b0); tick();
    chk("k1_ready", 32'(in_ready), 32'd0);
    chk("k1_alu",   32'(out_alu_result), 32'hA0);
    set_in(1'b1, 8'hA2, 1'b0); tick();
    chk("k2_ready", 32'(in_ready), 32'd0);
    chk("k2_alu",   32'(out_alu_result), 32'hA0);
    out_ready = 1'b1; tick();
    chk("k3_alu",   32'(out_alu_result), 32'hA1);
    chk("k3_valid", 32'(out_valid), 32'd1);
    chk("k3_ready", 32'(in_ready), 32'd1);
    tick();
    chk("k4_alu",   32'(out_alu_result), 32'hA2);
    chk("k4_valid", 32'(out_valid), 32'd1);
    set_in(1'b0, 8'h00, 1'b0); tick();
    chk("k5_valid", 32'(out_valid), 32'd0);

    // 4: flush while full, incoming B2 is dropped
    out_ready = 1'b0;
    set_in(1'b1, 8'hB0, 1'b1); tick();
    set_in(1'b1, 8'hB1, 1'b1); tick();
    chk("f_pre_ready", 32'(in_ready), 32'd0);
    chk("f_pre_mw",    32'(out_mem_write), 32'd1);
    set_in(1'b1, 8'hB2, 1'b1); flush = 1'b1; tick();
    chk("f_valid", 32'(out_valid), 32'd0);
    chk("f_ready", 32'(in_ready), 32'd1);
    chk("f_mw",    32'(out_mem_write), 32'd0);
    flush = 1'b0; out_ready = 1'b1;
    set_in(1'b0, 8'h00, 1'b0); tick();
    chk("f_post_valid", 32'(out_valid), 32'd0);
    set_in(1'b1, 8'hC0, 1'b1); tick();
    chk("f_c0_alu",   32'(out_alu_result), 32'hC0);
    chk("f_c0_valid", 32'(out_valid), 32'd1);

    // 5: bubbles with strobes asserted never reach MEM
    set_in(1'b0, 8'h55, 1'b1); tick();
    chk("b0_valid", 32'(out_valid), 32'd0);
    chk("b0_mw",    32'(out_mem_write), 32'd0);
    chk("b0_rw",    32'(out_reg_write), 32'd0);
    tick();
    chk("b1_mw",    32'(out_mem_write), 32'd0);
    chk("b1_rw",    32'(out_reg_write), 32'd0);

    // 6: reset while full discards both entries
    out_ready = 1'b0;
    set_in(1'b1, 8'hD0, 1'b1); tick();
    set_in(1'b1, 8'hD1, 1'b1); tick();
    chk("r_pre_ready", 32'(in_ready), 32'd0);
    set_in(1'b0, 8'h00, 1'b0); reset = 1'b0; tick();
    chk("r_valid", 32'(out_valid), 32'd0);
    chk("r_ready", 32'(in_ready), 32'd1);
    chk("r_alu",   32'(out_alu_result), 32'h0);
    chk("r_mw",    32'(out_mem_write), 32'd0);
    reset = 1'b1; out_ready = 1'b1;
    set_in(1'b1, 8'hE0, 1'b0); tick();
    chk("r_e0_alu",   32'(out_alu_result), 32'hE0);
    chk("r_e0_valid", 32'(out_valid), 32'd1);
    set_in(1'b0, 8'h00, 1'b0); tick();
    chk("r_end_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
